qerv_rf_ram_if: RTL and testbench
=================================

# qerv_rf_ram_if

Register-file RAM responder for the serial core. It accepts the per-slice read/write port traffic produced by the core's RF interface: two write ports (wreg/wen/wdata) and two read ports (rreg in, rdata out). It maps that traffic onto one external 1R1W synchronous RAM of `width` bits per word. Write slices are deserialized into RAM words; read words are serialized back into W-bit slices aligned for both read ports.

## Interface
Parameters:
- `W`, default 1: core slice width. Must divide `width`.
- `width`, default 8: RAM word width. Must divide 32, and `width/W` must be ≥ 2.
- Derived constants:
  - `N = 32/W`: slices per register.
  - `K = width/W`: slices per RAM word.
  - `RW`: register address width.
  - `AW = RW + log2(32/width)`: RAM address width.

Ports:
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_rreq`  in  1: pulse that starts a read transfer.
- `o_ready`  out  1: one-cycle pulse; read slices start on the next cycle.
- `i_wreg0`, `i_wreg1`  in  RW: write register addresses.
- `i_wen0`, `i_wen1`  in  1: per-slice write enables.
- `i_wdata0`, `i_wdata1`  in  W: write slices, LSB first.
- `i_rreg0`, `i_rreg1`  in  RW: read register addresses; held stable for the whole transfer.
- `o_rdata0`, `o_rdata1`  out  W: read slices, LSB first.
- `o_waddr`  out  AW, `o_wdata`  out  width, `o_wen`  out  1: RAM write port.
- `o_raddr`  out  AW, `o_ren`  out  1: RAM read port.
- `i_rdata`  in  width: RAM read data, valid one cycle after `o_ren`.

## Operation
- RAM address is `{reg, word}`, where `word` ranges 0..32/width−1. Register word j holds bits [j·width +: width].
- **Write path**
  - Each port has a `width`-bit shift buffer. A slice shifts in on each cycle its `wen` is high.
  - `wcnt` (log2 N bits) increments on any cycle with `i_wen0 | i_wen1` and wraps N−1 → 0.
  - When `wcnt[log2 K−1:0] == K−1`:
    - The port 0 word (if `wen0`) is written on the next cycle.
    - The port 1 word (if `wen1`) is staged and written the cycle after that.
    - Address is the port's `wreg` with word = `wcnt / K`.
  - Because K ≥ 2, the two writes never collide.
  - A port that is idle during a word produces no RAM write.
  - Writes must cover all N slices of a register. Partial transfers desynchronize `wcnt`; only `i_rst` recovers.
- **Read path**
  - A read transfer runs a sequencer with counter `rcnt`.
  - For word j: rreg0 is read at phase 0 and rreg1 at phase 1 of each K-cycle word period.
  - The rreg0 result is held in a staging register. Both words load into the per-port output shift buffers together.
  - Reads past the last word are not issued.
- **x0**: when a read register address is 0, that port's output is forced to 0 regardless of RAM contents.
- `i_rreq` during an active read restarts the sequencer from word 0.
- Read and write transfers run concurrently: separate RAM ports, independent counters.

## Timing
- Read, with `i_rreq` at cycle T:
  - RAM read of rreg0 word j at T+1+jK; rreg1 word j at T+2+jK.
  - Output buffers load word j at T+3+jK.
  - `o_ready` is high during T+2 only.
  - Slice s is presented at T+3+s, for s = 0..N−1.
  - Core consumption must be contiguous; no stalls.
- Write:
  - Port 0 word write lands 1 cycle after its last slice.
  - Port 1 word write lands 2 cycles after its last slice.
- Reset values: every output is 0, `wcnt` = `rcnt` = 0, sequencer idle.
- Reset mid-operation:
  - The transfer is abandoned.
  - No `o_wen` on the following cycle, and any staged port 1 write is dropped.
  - `o_ready` is not issued.

## Configuration
- `QERV_RF_CSR_EN` defined:
  - RW = 6; 36 registers: 32 GPRs plus CSRs at 32–35.
  - Write port 1 is active.
- `QERV_RF_CSR_EN` undefined:
  - RW = 5; 32 registers.
  - `i_wen1`/`i_wdata1` are ignored; there are no port 1 writes and the staging register is removed.
  - Read port 1 is unchanged.

## Structure
- Package `qerv_rf_pkg`:
  - GPR count (32).
  - CSR addresses: MSCRATCH 32, MTVEC 33, MEPC 34, MTVAL 35.
  - RW selection and the address-width helper function.
- Sub-module `qerv_rf_ser`: a per-port `width`→W load-and-shift serializer with x0 masking, instantiated twice.

## Test plan
Defaults W=1, width=8, macro defined.
- Port 0 writes x5 = 0xDEADBEEF over 32 cycles → RAM writes addr 20..23 with EF, BE, AD, DE, each one cycle after slices 7, 15, 23, 31.
- Port 0 writes x1 = 0x11223344 and port 1 writes MEPC (34) = 0xCAFEF00D simultaneously → each port 1 write is one cycle after the port 0 write; addresses 136..139 carry 0D, F0, FE, CA.
- After the first test, `i_rreq` at T with rreg0 = 5, rreg1 = 34 → `o_ready` at T+2; 0xDEADBEEF on `o_rdata0` and 0xCAFEF00D on `o_rdata1`, LSB first, T+3..T+34.
- RAM word(s) of reg 0 preset to 0xFF, read rreg0 = 0 → `o_rdata0` stays 0 for all 32 slices.
- `i_rst` after write slice 12 → no `o_wen` from that cycle on. A following full write of x7 = 0x0000FFFF lands correctly at addr 28..31.
- Macro undefined, `i_wen1` asserted for 32 cycles → zero RAM writes; `o_waddr` is 7 bits wide.

Source files
------------

// File: rtl/qerv_rf_pkg.sv
// Shared constants for the serial-core register file: register counts, CSR slots, address widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Build option: QERV_RF_CSR_EN adds four CSR registers (32..35) and a 6-bit register address.
package qerv_rf_pkg;

  localparam int GPR_COUNT    = 32;
  localparam int CSR_MSCRATCH = 32;
  localparam int CSR_MTVEC    = 33;
  localparam int CSR_MEPC     = 34;
  localparam int CSR_MTVAL    = 35;

`ifdef QERV_RF_CSR_EN
  localparam int RF_RW   = 6;
  localparam int RF_REGS = GPR_COUNT + 4;
`else
  localparam int RF_RW   = 5;
  localparam int RF_REGS = GPR_COUNT;
`endif

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // RAM address width: register address plus word-within-register index.
  function automatic int rf_aw(input int rw, input int word_width);
    return rw + $clog2(32 / word_width);
  endfunction

endpackage

// File: rtl/qerv_rf_ser.sv
// Load-and-shift serializer: turns a RAM word into W-bit slices, LSB first, with x0 masking.
// Latency: slice 0 appears combinationally in the load cycle; slice k follows k cycles later.
// Backpressure: none; the consumer must take one slice per cycle.
// Ports: i_clk/i_rst clock and sync reset, i_load/i_word word load, i_reg read register
// (zero forces output 0), o_dat current slice.
module qerv_rf_ser #(
  parameter int W     = 1,
  parameter int width = 8,
  parameter int RW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [width-1:0] i_word,
  input  logic [RW-1:0]    i_reg,
  output logic [W-1:0]     o_dat
);

  logic [width-1:0] r_buf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
    end else if (i_load) begin
      // Slice 0 goes out directly this cycle, so keep only the remainder.
      r_buf <= i_word >> W;
    end else begin
      r_buf <= r_buf >> W;
    end
  end

  // Register x0 always reads as zero no matter what the RAM holds.
  assign o_dat = (i_reg == '0) ? '0 : (i_load ? i_word[W-1:0] : r_buf[W-1:0]);

endmodule

// File: rtl/qerv_rf_ram_if.sv
// Register-file RAM responder: deserializes core write slices into RAM words and serializes
// RAM read words back into slices for both read ports.
// Latency: port 0 write 1 cycle after last slice, port 1 write 2 cycles; read slices from rreq+3.
// Backpressure: none; write and read slice streams must be contiguous.
// Ports: i_clk/i_rst; i_rreq/o_ready read handshake; i_wreg*/i_wen*/i_wdata* write slices;
// i_rreg*/o_rdata* read slices; o_waddr/o_wdata/o_wen and o_raddr/o_ren/i_rdata to the 1R1W RAM.
// Build option: QERV_RF_CSR_EN enables write port 1 and the CSR address space.
module qerv_rf_ram_if
  import qerv_rf_pkg::*;
#(
  parameter int W      = 1,
  parameter int width  = 8,
  localparam int RW    = RF_RW,
  localparam int AW    = rf_aw(RF_RW, width)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  localparam int N  = 32 / W;
  localparam int K  = width / W;
  localparam int NW = 32 / width;
  localparam int LN = $clog2(N);
  localparam int LK = $clog2(K);
  localparam int LW = $clog2(NW);
  localparam int LR = LN + 1;  // read counter runs a little past N-1 for small K

  // ---------------- write path ----------------
  logic [LN-1:0]    r_wcnt;
  logic [width-1:0] r_wbuf0;
  logic             r_wen;
  logic [AW-1:0]    r_waddr;
  logic [width-1:0] r_wdata;
  logic             w_wact;
  logic             w_wlast;
  logic [LN-1:0]    w_widx;
  logic [width-1:0] w_wword0;
  logic [AW-1:0]    w_waddr0;

`ifdef QERV_RF_CSR_EN
  logic [width-1:0] r_wbuf1;
  logic [width-1:0] w_wword1;
  logic             r_p1_vld;
  logic [AW-1:0]    r_p1_addr;
  logic [width-1:0] r_p1_data;
  assign w_wact   = i_wen0 | i_wen1;
  assign w_wword1 = {i_wdata1, r_wbuf1[width-1:W]};
`else
  logic w_unused;
  assign w_wact   = i_wen0;
  assign w_unused = &{1'b0, i_wen1, i_wdata1, i_wreg1};
`endif

  assign w_wlast  = (r_wcnt[LK-1:0] == LK'(K - 1));
  assign w_widx   = r_wcnt >> LK;
  assign w_wword0 = {i_wdata0, r_wbuf0[width-1:W]};
  assign w_waddr0 = (AW'(i_wreg0) << LW) | AW'(w_widx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt  <= '0;
      r_wbuf0 <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
`ifdef QERV_RF_CSR_EN
      r_wbuf1   <= '0;
      r_p1_vld  <= 1'b0;
      r_p1_addr <= '0;
      r_p1_data <= '0;
`endif
    end else begin
      r_wen <= 1'b0;
      if (w_wact) r_wcnt <= r_wcnt + LN'(1);
      if (i_wen0) r_wbuf0 <= w_wword0;
`ifdef QERV_RF_CSR_EN
      // Port 1 word waits one cycle so it never shares the RAM write port with port 0.
      if (i_wen1) r_wbuf1 <= w_wword1;
      r_p1_vld <= i_wen1 && w_wlast;
      if (i_wen1 && w_wlast) begin
        r_p1_addr <= (AW'(i_wreg1) << LW) | AW'(w_widx);
        r_p1_data <= w_wword1;
      end
      if (r_p1_vld) begin
        r_wen   <= 1'b1;
        r_waddr <= r_p1_addr;
        r_wdata <= r_p1_data;
      end
`endif
      if (i_wen0 && w_wlast) begin
        r_wen   <= 1'b1;
        r_waddr <= w_waddr0;
        r_wdata <= w_wword0;
      end
    end
  end

  assign o_wen   = r_wen;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

  // ---------------- read path ----------------
  rd_state_t        r_rstate, w_rstate_nxt;
  logic [LR-1:0]    r_rcnt, w_rcnt_nxt;
  logic [width-1:0] r_rstage;
  logic [LR-1:0]    w_rword, w_lcnt, w_lword;
  logic             w_stage_en;
  logic             w_rload;

  assign w_rword = r_rcnt >> LK;
  // Loads trail the rreg0 read by two cycles; w_lcnt re-bases the counter onto load phase.
  assign w_lcnt  = r_rcnt - LR'(2);
  assign w_lword = w_lcnt >> LK;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rstate <= RD_IDLE;
      r_rcnt   <= '0;
      r_rstage <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rcnt   <= w_rcnt_nxt;
      if (w_stage_en) r_rstage <= i_rdata;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rcnt_nxt   = r_rcnt;
    o_ren        = 1'b0;
    o_raddr      = '0;
    o_ready      = 1'b0;
    w_stage_en   = 1'b0;
    w_rload      = 1'b0;
    if (r_rstate == RD_RUN && !i_rst) begin
      w_rcnt_nxt = r_rcnt + LR'(1);
      if (w_rword < LR'(NW)) begin
        if (r_rcnt[LK-1:0] == LK'(0)) begin
          o_ren   = 1'b1;
          o_raddr = (AW'(i_rreg0) << LW) | AW'(w_rword);
        end
        if (r_rcnt[LK-1:0] == LK'(1)) begin
          o_ren      = 1'b1;
          o_raddr    = (AW'(i_rreg1) << LW) | AW'(w_rword);
          w_stage_en = 1'b1;  // rreg0 data for this word is on i_rdata now
        end
      end
      if (r_rcnt == LR'(1)) o_ready = 1'b1;
      if (r_rcnt >= LR'(2) && w_lcnt[LK-1:0] == LK'(0) && w_lword < LR'(NW)) begin
        w_rload = 1'b1;
        if (w_lword == LR'(NW - 1)) begin
          w_rstate_nxt = RD_IDLE;
          w_rcnt_nxt   = '0;
        end
      end
    end
    if (i_rreq) begin
      w_rstate_nxt = RD_RUN;
      w_rcnt_nxt   = '0;
    end
  end

  qerv_rf_ser #(.W(W), .width(width), .RW(RW)) u_ser0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_rload),
    .i_word (r_rstage),
    .i_reg  (i_rreg0),
    .o_dat  (o_rdata0)
  );

  qerv_rf_ser #(.W(W), .width(width), .RW(RW)) u_ser1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_rload),
    .i_word (i_rdata),
    .i_reg  (i_rreg1),
    .o_dat  (o_rdata1)
  );

endmodule

// File: tb/tb_qerv_rf_ram_if.sv
// Directed bench for qerv_rf_ram_if (W=1, width=8) with a behavioural 1R1W RAM.
// Adapts to QERV_RF_CSR_EN: dual-port writes when defined, port-1-ignored checks otherwise.
module tb_qerv_rf_ram_if;
  import qerv_rf_pkg::*;

  localparam int RW    = RF_RW;
  localparam int TB_AW = rf_aw(RF_RW, 8);

  logic clk = 1'b0;
  logic i_rst, i_rreq, i_wen0, i_wen1, o_ready, o_wen, o_ren;
  logic [RW-1:0] i_wreg0, i_wreg1, i_rreg0, i_rreg1;
  logic [0:0] i_wdata0, i_wdata1, o_rdata0, o_rdata1;
  logic [TB_AW-1:0] o_waddr, o_raddr;
  logic [7:0] o_wdata;
  logic [7:0] ram_rdata = '0;
  logic [7:0] mem [0:(1<<TB_AW)-1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int slice_cyc [32];
  int mon_addr [$];
  int mon_data [$];
  int mon_cyc  [$];

  qerv_rf_ram_if dut (
    .i_clk(clk), .i_rst(i_rst), .i_rreq(i_rreq), .o_ready(o_ready),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_wen(o_wen), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(ram_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_wen === 1'b1) mem[o_waddr] <= o_wdata;
    if (o_ren === 1'b1) ram_rdata <= mem[o_raddr];
  end

  always @(negedge clk) begin
    if (o_wen === 1'b1) begin
      mon_addr.push_back(int'(o_waddr));
      mon_data.push_back(int'(o_wdata));
      mon_cyc.push_back(cyc);
    end
  end

  task automatic write_reg(input logic e0, input logic [RW-1:0] r0, input logic [31:0] d0,
                           input logic e1, input logic [RW-1:0] r1, input logic [31:0] d1,
                           input int nslices);
    for (int s = 0; s < nslices; s++) begin
      @(negedge clk);
      i_wen0 = e0; i_wreg0 = r0; i_wdata0 = d0[s];
      i_wen1 = e1; i_wreg1 = r1; i_wdata1 = d1[s];
      slice_cyc[s] = cyc;
    end
    @(negedge clk);
    i_wen0 = 1'b0; i_wen1 = 1'b0;
  endtask

  task automatic do_read(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                         output logic [31:0] g0, output logic [31:0] g1,
                         output int rdy_at, output int rdy_n, output int ren_n);
    g0 = '0; g1 = '0; rdy_at = -1; rdy_n = 0; ren_n = 0;
    @(negedge clk);
    i_rreg0 = r0; i_rreg1 = r1; i_rreq = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      i_rreq = 1'b0;
      if (o_ready === 1'b1) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = k;
      end
      if (o_ren === 1'b1) ren_n++;
      if (k >= 3 && k <= 34) begin
        g0[k-3] = o_rdata0;
        g1[k-3] = o_rdata1;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL reset_o_wen got=%b want=0", o_wen); end
    n_cmp++; if (o_ren !== 1'b0) begin n_bad++; $display("FAIL reset_o_ren got=%b want=0", o_ren); end
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_o_ready got=%b want=0", o_ready); end
    n_cmp++; if (o_rdata0 !== 1'b0) begin n_bad++; $display("FAIL reset_o_rdata0 got=%b want=0", o_rdata0); end
    n_cmp++; if (o_rdata1 !== 1'b0) begin n_bad++; $display("FAIL reset_o_rdata1 got=%b want=0", o_rdata1); end
    n_cmp++; if (o_waddr !== '0) begin n_bad++; $display("FAIL reset_o_waddr got=%0d want=0", o_waddr); end
    n_cmp++; if (o_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_o_wdata got=%h want=00", o_wdata); end
    n_cmp++; if (o_raddr !== '0) begin n_bad++; $display("FAIL reset_o_raddr got=%0d want=0", o_raddr); end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_p0();
    int base;
    logic [31:0] d;
    d = 32'hDEADBEEF;
    base = mon_addr.size();
    write_reg(1'b1, RW'(5), d, 1'b0, '0, '0, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 4) begin
      n_bad++; $display("FAIL p0_write_count got=%0d want=4", mon_addr.size() - base);
    end
    for (int j = 0; j < 4; j++) begin
      if (base + j < mon_addr.size()) begin
        n_cmp++; if (mon_addr[base+j] !== 20 + j) begin n_bad++; $display("FAIL p0_addr[%0d] got=%0d want=%0d", j, mon_addr[base+j], 20 + j); end
        n_cmp++; if (mon_data[base+j] !== int'(d[8*j +: 8])) begin n_bad++; $display("FAIL p0_data[%0d] got=%h want=%h", j, mon_data[base+j], d[8*j +: 8]); end
        n_cmp++; if (mon_cyc[base+j] !== slice_cyc[8*j+7] + 1) begin n_bad++; $display("FAIL p0_time[%0d] got=%0d want=%0d", j, mon_cyc[base+j], slice_cyc[8*j+7] + 1); end
      end
    end
  endtask

`ifdef QERV_RF_CSR_EN
  task automatic test_dual_write();
    int base;
    logic [31:0] d0, d1;
    d0 = 32'h11223344;
    d1 = 32'hCAFEF00D;
    base = mon_addr.size();
    write_reg(1'b1, RW'(1), d0, 1'b1, RW'(CSR_MEPC), d1, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 8) begin
      n_bad++; $display("FAIL dual_write_count got=%0d want=8", mon_addr.size() - base);
    end
    for (int j = 0; j < 4; j++) begin
      if (base + 2*j + 1 < mon_addr.size()) begin
        n_cmp++; if (mon_addr[base+2*j] !== 4 + j) begin n_bad++; $display("FAIL dual_p0_addr[%0d] got=%0d want=%0d", j, mon_addr[base+2*j], 4 + j); end
        n_cmp++; if (mon_data[base+2*j] !== int'(d0[8*j +: 8])) begin n_bad++; $display("FAIL dual_p0_data[%0d] got=%h want=%h", j, mon_data[base+2*j], d0[8*j +: 8]); end
        n_cmp++; if (mon_cyc[base+2*j] !== slice_cyc[8*j+7] + 1) begin n_bad++; $display("FAIL dual_p0_time[%0d] got=%0d want=%0d", j, mon_cyc[base+2*j], slice_cyc[8*j+7] + 1); end
        n_cmp++; if (mon_addr[base+2*j+1] !== 136 + j) begin n_bad++; $display("FAIL dual_p1_addr[%0d] got=%0d want=%0d", j, mon_addr[base+2*j+1], 136 + j); end
        n_cmp++; if (mon_data[base+2*j+1] !== int'(d1[8*j +: 8])) begin n_bad++; $display("FAIL dual_p1_data[%0d] got=%h want=%h", j, mon_data[base+2*j+1], d1[8*j +: 8]); end
        n_cmp++; if (mon_cyc[base+2*j+1] !== slice_cyc[8*j+7] + 2) begin n_bad++; $display("FAIL dual_p1_time[%0d] got=%0d want=%0d", j, mon_cyc[base+2*j+1], slice_cyc[8*j+7] + 2); end
      end
    end
  endtask
`else
  task automatic test_wen1_ignored();
    int base;
    logic [31:0] d0;
    d0 = 32'h11223344;
    base = mon_addr.size();
    write_reg(1'b0, '0, '0, 1'b1, RW'(9), 32'hCAFEF00D, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 0) begin
      n_bad++; $display("FAIL wen1_only_writes got=%0d want=0", mon_addr.size() - base);
    end
    base = mon_addr.size();
    write_reg(1'b1, RW'(1), d0, 1'b1, RW'(9), 32'hCAFEF00D, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 4) begin
      n_bad++; $display("FAIL wen1_mixed_count got=%0d want=4", mon_addr.size() - base);
    end
    for (int j = 0; j < 4; j++) begin
      if (base + j < mon_addr.size()) begin
        n_cmp++; if (mon_addr[base+j] !== 4 + j) begin n_bad++; $display("FAIL wen1_mixed_addr[%0d] got=%0d want=%0d", j, mon_addr[base+j], 4 + j); end
        n_cmp++; if (mon_data[base+j] !== int'(d0[8*j +: 8])) begin n_bad++; $display("FAIL wen1_mixed_data[%0d] got=%h want=%h", j, mon_data[base+j], d0[8*j +: 8]); end
      end
    end
  endtask
`endif

  task automatic test_read();
    logic [31:0] g0, g1, e1;
    logic [RW-1:0] r1;
    int rdy_at, rdy_n, ren_n;
`ifdef QERV_RF_CSR_EN
    r1 = RW'(CSR_MEPC); e1 = 32'hCAFEF00D;
`else
    r1 = RW'(1); e1 = 32'h11223344;
`endif
    do_read(RW'(5), r1, g0, g1, rdy_at, rdy_n, ren_n);
    n_cmp++; if (rdy_at !== 2) begin n_bad++; $display("FAIL read_ready_time got=%0d want=2", rdy_at); end
    n_cmp++; if (rdy_n !== 1) begin n_bad++; $display("FAIL read_ready_pulses got=%0d want=1", rdy_n); end
    n_cmp++; if (ren_n !== 8) begin n_bad++; $display("FAIL read_ren_count got=%0d want=8", ren_n); end
    n_cmp++; if (g0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata0 got=%h want=deadbeef", g0); end
    n_cmp++; if (g1 !== e1) begin n_bad++; $display("FAIL read_rdata1 got=%h want=%h", g1, e1); end
  endtask

  task automatic test_x0();
    int base;
    logic [31:0] g0, g1;
    int rdy_at, rdy_n, ren_n;
    base = mon_addr.size();
    write_reg(1'b1, '0, 32'hFFFFFFFF, 1'b0, '0, '0, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 4) begin
      n_bad++; $display("FAIL x0_preset_count got=%0d want=4", mon_addr.size() - base);
    end
    if (base + 3 < mon_addr.size()) begin
      n_cmp++; if (mon_addr[base+3] !== 3) begin n_bad++; $display("FAIL x0_preset_addr got=%0d want=3", mon_addr[base+3]); end
      n_cmp++; if (mon_data[base+3] !== 8'hFF) begin n_bad++; $display("FAIL x0_preset_data got=%h want=ff", mon_data[base+3]); end
    end
    do_read('0, RW'(5), g0, g1, rdy_at, rdy_n, ren_n);
    n_cmp++; if (g0 !== 32'h0) begin n_bad++; $display("FAIL x0_rdata0 got=%h want=00000000", g0); end
    n_cmp++; if (g1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL x0_rdata1 got=%h want=deadbeef", g1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g0, g1;
    int rdy_at, rdy_n, ren_n;
    @(negedge clk);
    i_rreg0 = RW'(5); i_rreg1 = RW'(5); i_rreq = 1'b1;
    repeat (5) begin
      @(negedge clk);
      i_rreq = 1'b0;
    end
    do_read(RW'(1), RW'(5), g0, g1, rdy_at, rdy_n, ren_n);
    n_cmp++; if (rdy_at !== 2) begin n_bad++; $display("FAIL restart_ready_time got=%0d want=2", rdy_at); end
    n_cmp++; if (rdy_n !== 1) begin n_bad++; $display("FAIL restart_ready_pulses got=%0d want=1", rdy_n); end
    n_cmp++; if (g0 !== 32'h11223344) begin n_bad++; $display("FAIL restart_rdata0 got=%h want=11223344", g0); end
    n_cmp++; if (g1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL restart_rdata1 got=%h want=deadbeef", g1); end
  endtask

  task automatic test_reset_mid_write();
    int base;
    logic [31:0] d;
    write_reg(1'b1, RW'(7), 32'h12345678, 1'b0, '0, '0, 13);
    base = mon_addr.size();
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 0) begin
      n_bad++; $display("FAIL rst_write_stray got=%0d want=0", mon_addr.size() - base);
    end
    d = 32'h0000FFFF;
    base = mon_addr.size();
    write_reg(1'b1, RW'(7), d, 1'b0, '0, '0, 32);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon_addr.size() - base !== 4) begin
      n_bad++; $display("FAIL rst_rewrite_count got=%0d want=4", mon_addr.size() - base);
    end
    for (int j = 0; j < 4; j++) begin
      if (base + j < mon_addr.size()) begin
        n_cmp++; if (mon_addr[base+j] !== 28 + j) begin n_bad++; $display("FAIL rst_rewrite_addr[%0d] got=%0d want=%0d", j, mon_addr[base+j], 28 + j); end
        n_cmp++; if (mon_data[base+j] !== int'(d[8*j +: 8])) begin n_bad++; $display("FAIL rst_rewrite_data[%0d] got=%h want=%h", j, mon_data[base+j], d[8*j +: 8]); end
        n_cmp++; if (mon_cyc[base+j] !== slice_cyc[8*j+7] + 1) begin n_bad++; $display("FAIL rst_rewrite_time[%0d] got=%0d want=%0d", j, mon_cyc[base+j], slice_cyc[8*j+7] + 1); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int rdy_n, ren_n;
    rdy_n = 0; ren_n = 0;
    @(negedge clk);
    i_rreg0 = RW'(5); i_rreg1 = RW'(1); i_rreq = 1'b1;
    @(negedge clk);
    i_rreq = 1'b0; i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    if (o_ready === 1'b1) rdy_n++;
    if (o_ren === 1'b1) ren_n++;
    repeat (8) begin
      @(negedge clk);
      if (o_ready === 1'b1) rdy_n++;
      if (o_ren === 1'b1) ren_n++;
    end
    n_cmp++; if (rdy_n !== 0) begin n_bad++; $display("FAIL rst_read_ready got=%0d want=0", rdy_n); end
    n_cmp++; if (ren_n !== 0) begin n_bad++; $display("FAIL rst_read_ren got=%0d want=0", ren_n); end
  endtask

  initial begin
    i_rst = 1'b1; i_rreq = 1'b0; i_wen0 = 1'b0; i_wen1 = 1'b0;
    i_wreg0 = '0; i_wreg1 = '0; i_wdata0 = '0; i_wdata1 = '0;
    i_rreg0 = '0; i_rreg1 = '0;
    test_reset();
    test_write_p0();
`ifdef QERV_RF_CSR_EN
    test_dual_write();
`else
    test_wen1_ignored();
`endif
    test_read();
    test_x0();
    test_back_to_back();
    test_reset_mid_write();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
